// File: rtl/cci_mpf_prim_throttle_pkg.sv
// Shared types for the active-request throttle: tracker count widths and
// the drain state encoding.
package cci_mpf_prim_throttle_pkg;

    localparam int MAX_ACTIVE_LINES_DFLT    = 512;
    localparam int MAX_ACTIVE_WRFENCES_DFLT = 32;

    typedef logic [$clog2(MAX_ACTIVE_LINES_DFLT):0]     t_active_cnt;
    typedef logic [$clog2(MAX_ACTIVE_WRFENCES_DFLT)-1:0] t_active_wrfence_cnt;
    typedef logic [$clog2(MAX_ACTIVE_LINES_DFLT)+1:0]   t_est_cnt;

    typedef enum logic [1:0] {
        DRAIN_IDLE  = 2'd0,
        DRAIN_BLOCK = 2'd1,
        DRAIN_WAIT  = 2'd2,
        DRAIN_DONE  = 2'd3
    } t_drain_state;

endpackage

// File: rtl/cci_mpf_prim_lag_window.sv
// Sliding sum of the lines issued over the last LAG cycles, covering the
// requests the tracker has not yet folded into its counts.
module cci_mpf_prim_lag_window #(
    parameter int LAG   = 2,
    parameter int SUM_W = $clog2(4*LAG+1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       i_lines,
    output logic [SUM_W-1:0] o_sum
);

    logic [2:0]       r_shift [LAG];
    logic [SUM_W-1:0] r_sum;
    logic [2:0]       w_exit;

    assign w_exit = r_shift[LAG-1];
    assign o_sum  = r_sum;

    // Incremental update: the value entering is added while the one falling
    // off the end of the window is removed in the same cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < LAG; i++) begin
                r_shift[i] <= 3'd0;
            end
            r_sum <= '0;
        end else begin
            r_shift[0] <= i_lines;
            for (int i = 1; i < LAG; i++) begin
                r_shift[i] <= r_shift[i-1];
            end
            r_sum <= r_sum + SUM_W'(i_lines) - SUM_W'(w_exit);
        end
    end

endmodule

// File: rtl/cci_mpf_prim_active_req_throttle.sv
// Per-channel almost-full back-pressure from lag-compensated line estimates,
// plus a drain handshake that blocks traffic and acks once the bus is empty.
module cci_mpf_prim_active_req_throttle
    import cci_mpf_prim_throttle_pkg::*;
#(
    parameter int MAX_ACTIVE_LINES    = 512,
    parameter int MAX_ACTIVE_WRFENCES = 32,
    parameter int LAG                 = 2,
    parameter int ALMOST_FULL_SLACK   = 8
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic [$clog2(MAX_ACTIVE_LINES):0]      c0_active_lines,
    input  logic [$clog2(MAX_ACTIVE_LINES):0]      c1_active_lines,
    input  logic [$clog2(MAX_ACTIVE_WRFENCES)-1:0] c1_active_wrfences,
    input  logic                                   c0_not_empty,
    input  logic                                   c1_not_empty,
    input  logic [2:0]                             c0_req_lines,
    input  logic [2:0]                             c1_req_lines,
    output logic                                   c0_almost_full,
    output logic                                   c1_almost_full,
    input  logic                                   drain_req,
    output logic                                   drain_ack,
    output logic                                   drain_busy,
    output t_drain_state                           o_dbg_drain_state
);

    localparam int SUM_W      = $clog2(4*LAG+1);
    localparam int EST_W      = $clog2(MAX_ACTIVE_LINES) + 2;
    localparam int THRESH     = MAX_ACTIVE_LINES - 4*(ALMOST_FULL_SLACK+1);
    localparam int SLACK_LOAD = ALMOST_FULL_SLACK + LAG + 1;
    localparam int SLACK_W    = $clog2(SLACK_LOAD+1);

    logic [SUM_W-1:0]   w_c0_sum;
    logic [SUM_W-1:0]   w_c1_sum;
    logic [EST_W-1:0]   w_c0_est;
    logic [EST_W-1:0]   w_c1_est;
    logic               w_c0_hit;
    logic               w_c1_hit;
    logic               w_quiet;

    t_drain_state       r_state;
    logic [SLACK_W-1:0] r_slack;
    logic               r_busy;
    logic               r_ack;
    logic               r_c0_af;
    logic               r_c1_af;

    cci_mpf_prim_lag_window #(.LAG(LAG), .SUM_W(SUM_W)) u_c0_window (
        .clk     (clk),
        .reset_n (reset_n),
        .i_lines (c0_req_lines),
        .o_sum   (w_c0_sum)
    );

    cci_mpf_prim_lag_window #(.LAG(LAG), .SUM_W(SUM_W)) u_c1_window (
        .clk     (clk),
        .reset_n (reset_n),
        .i_lines (c1_req_lines),
        .o_sum   (w_c1_sum)
    );

    // Estimates are one bit wider than the tracker counts so oversized
    // counts plus the window never wrap below the threshold.
    assign w_c0_est = EST_W'(c0_active_lines) + EST_W'(w_c0_sum);
    assign w_c1_est = EST_W'(c1_active_lines) + EST_W'(w_c1_sum);
    assign w_c0_hit = (w_c0_est >= EST_W'(THRESH));
    assign w_c1_hit = (w_c1_est >= EST_W'(THRESH));

    assign w_quiet = !c0_not_empty && !c1_not_empty &&
                     (c1_active_wrfences == '0) &&
                     (w_c0_sum == '0) && (w_c1_sum == '0);

    // From every state the next busy value equals drain_req (idle starts,
    // busy states abort or hold), so drain_req itself is the force term.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= DRAIN_IDLE;
            r_slack <= '0;
            r_busy  <= 1'b0;
            r_ack   <= 1'b0;
            r_c0_af <= 1'b0;
            r_c1_af <= 1'b0;
        end else begin
            r_c0_af <= w_c0_hit | drain_req;
            r_c1_af <= w_c1_hit | drain_req;
            case (r_state)
                DRAIN_IDLE: begin
                    if (drain_req) begin
                        r_state <= DRAIN_BLOCK;
                        r_slack <= SLACK_W'(SLACK_LOAD);
                        r_busy  <= 1'b1;
                    end
                end
                DRAIN_BLOCK: begin
                    if (!drain_req) begin
                        r_state <= DRAIN_IDLE;
                        r_slack <= '0;
                        r_busy  <= 1'b0;
                    end else begin
                        r_slack <= r_slack - 1'b1;
                        if (r_slack == SLACK_W'(1)) begin
                            r_state <= DRAIN_WAIT;
                        end
                    end
                end
                DRAIN_WAIT: begin
                    if (!drain_req) begin
                        r_state <= DRAIN_IDLE;
                        r_busy  <= 1'b0;
                    end else if (w_quiet) begin
                        r_state <= DRAIN_DONE;
                        r_ack   <= 1'b1;
                    end
                end
                DRAIN_DONE: begin
                    if (!drain_req) begin
                        r_state <= DRAIN_IDLE;
                        r_busy  <= 1'b0;
                        r_ack   <= 1'b0;
                    end
                end
                default: begin
                    r_state <= DRAIN_IDLE;
                    r_busy  <= 1'b0;
                    r_ack   <= 1'b0;
                end
            endcase
        end
    end

    assign c0_almost_full    = r_c0_af;
    assign c1_almost_full    = r_c1_af;
    assign drain_ack         = r_ack;
    assign drain_busy        = r_busy;
    assign o_dbg_drain_state = r_state;

endmodule
